if_stage: RTL and testbench

Instruction-fetch stage of the five-stage LoongArch-subset pipeline. It owns the program counter and drives the synchronous instruction SRAM address and enable. It produces `fs_to_ds_bus` and `pc_valid` for the decode stage. It resolves redirects from exception flush and branch resolution, and holds a branch redirect that arrives while fetch is stalled. It also detects misaligned-fetch (ADEF) exceptions and forwards them down the pipe.

---
 rtl/if_stage.sv | 99 +++++++++
 tb/tb_if_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and builds the fetch-to-decode bus.
// Optional misaligned-fetch (ADEF) detection is enabled by defining IF_ADEF_CHECK_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
    parameter int          FS_TO_DS_BUS_WD = 65
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    input  logic [5:0]                 stall,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    output logic                       pc_valid,
    output logic                       inst_sram_en,
    output logic [31:0]                inst_sram_addr,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

    logic [31:0] fs_pc_q,       fs_pc_d;
    logic        valid_q,       valid_d;
    logic        pend_v_q,      pend_v_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] next_pc_s;
    logic        excp_adef_s;
    logic [31:0] fs_badv_s;
    logic        unused_stall_s;

    // Only stall[0] concerns fetch; the rest of the vector belongs to later stages.
    assign unused_stall_s = ^stall[5:1];

    // Redirect priority: flush, then a fresh branch, then a branch held over a stall.
    always_comb begin
        next_pc_s = fs_pc_q + 32'd4;
        if (flush) begin
            next_pc_s = flush_pc;
        end else if (br_taken) begin
            next_pc_s = br_target;
        end else if (pend_v_q) begin
            next_pc_s = pend_target_q;
        end else begin
            next_pc_s = fs_pc_q + 32'd4;
        end
    end

    // Next-state: flush ignores stall; a branch seen while stalled is parked until the stall drops.
    always_comb begin
        fs_pc_d       = fs_pc_q;
        valid_d       = valid_q;
        pend_v_d      = pend_v_q;
        pend_target_d = pend_target_q;
        if (flush) begin
            fs_pc_d  = flush_pc;
            valid_d  = 1'b1;
            pend_v_d = 1'b0;
        end else if (!stall[0]) begin
            fs_pc_d  = next_pc_s;
            valid_d  = 1'b1;
            pend_v_d = 1'b0;
        end else if (br_taken) begin
            pend_v_d      = 1'b1;
            pend_target_d = br_target;
        end else begin
            pend_v_d = pend_v_q;
        end
    end

    // State registers with synchronous reset; PC starts one word early so the first fetch is RESET_PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_pc_q       <= RESET_PC - 32'd4;
            valid_q       <= 1'b0;
            pend_v_q      <= 1'b0;
            pend_target_q <= 32'h0000_0000;
        end else begin
            fs_pc_q       <= fs_pc_d;
            valid_q       <= valid_d;
            pend_v_q      <= pend_v_d;
            pend_target_q <= pend_target_d;
        end
    end

`ifdef IF_ADEF_CHECK_EN
    // A misaligned PC is reported downstream and never issued to the SRAM.
    assign excp_adef_s    = valid_q & (fs_pc_q[1:0] != 2'b00);
    assign fs_badv_s      = excp_adef_s ? fs_pc_q : 32'h0000_0000;
    assign inst_sram_en   = valid_q & ~excp_adef_s;
    assign inst_sram_addr = fs_pc_q;
`else
    assign excp_adef_s    = 1'b0;
    assign fs_badv_s      = 32'h0000_0000;
    assign inst_sram_en   = valid_q;
    assign inst_sram_addr = {fs_pc_q[31:2], 2'b00};
`endif

    assign pc_valid     = valid_q;
    assign fs_to_ds_bus = {fs_badv_s, excp_adef_s, fs_pc_q};

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; expectations follow IF_ADEF_CHECK_EN if the bench is built with it.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, flush, br_taken;
    logic [31:0] flush_pc, br_target;
    logic [5:0]  stall;
    logic        pc_valid, inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [64:0] fs_to_ds_bus;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .pc_valid(pc_valid), .inst_sram_en(inst_sram_en),
        .inst_sram_addr(inst_sram_addr), .fs_to_ds_bus(fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for a valid fetch at the given PC.
    task automatic chk_fetch(input string tag, input logic [31:0] pc);
        logic        adef;
        logic [31:0] addr;
`ifdef IF_ADEF_CHECK_EN
        adef = (pc[1:0] != 2'b00);
        addr = pc;
`else
        adef = 1'b0;
        addr = {pc[31:2], 2'b00};
`endif
        check({tag, ".valid"}, {64'd0, pc_valid}, 65'd1);
        check({tag, ".en"},    {64'd0, inst_sram_en}, {64'd0, ~adef});
        check({tag, ".addr"},  {33'd0, inst_sram_addr}, {33'd0, addr});
        check({tag, ".bus"},   fs_to_ds_bus, {(adef ? pc : 32'h0), adef, pc});
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".valid"}, {64'd0, pc_valid}, 65'd0);
        check({tag, ".en"},    {64'd0, inst_sram_en}, 65'd0);
        check({tag, ".addr"},  {33'd0, inst_sram_addr}, {33'd0, 32'h1BFF_FFFC});
        check({tag, ".bus"},   fs_to_ds_bus, {32'h0, 1'b0, 32'h1BFF_FFFC});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; br_taken = 1'b0; stall = 6'd0;
        flush_pc = 32'h0; br_target = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset("rst");
        end

        reset = 1'b0;
        tick(); chk_fetch("seq0", 32'h1C00_0000);
        tick(); chk_fetch("seq1", 32'h1C00_0004);
        tick(); chk_fetch("seq2", 32'h1C00_0008);

        br_taken = 1'b1; br_target = 32'h1C00_0100;
        tick(); chk_fetch("br0", 32'h1C00_0100);
        br_taken = 1'b0;
        tick(); chk_fetch("br1", 32'h1C00_0104);

        // Branch arrives in the middle of a three-cycle stall.
        stall = 6'd1;
        tick(); chk_fetch("stl0", 32'h1C00_0104);
        br_taken = 1'b1; br_target = 32'h1C00_0200;
        tick(); chk_fetch("stl1", 32'h1C00_0104);
        br_taken = 1'b0;
        tick(); chk_fetch("stl2", 32'h1C00_0104);
        stall = 6'd0;
        tick(); chk_fetch("stl_rel", 32'h1C00_0200);
        tick(); chk_fetch("stl_after", 32'h1C00_0204);

        // Flush beats a simultaneous branch, even while stalled.
        stall = 6'd1; flush = 1'b1; flush_pc = 32'h1C00_8000;
        br_taken = 1'b1; br_target = 32'h1C00_0300;
        tick(); chk_fetch("fl0", 32'h1C00_8000);
        flush = 1'b0; br_taken = 1'b0;
        tick(); chk_fetch("fl_hold", 32'h1C00_8000);
        stall = 6'd0;
        tick(); chk_fetch("fl_nobr", 32'h1C00_8004);

        // Flush discards an already pending branch.
        stall = 6'd1; br_taken = 1'b1; br_target = 32'h1C00_0400;
        tick(); chk_fetch("pf0", 32'h1C00_8004);
        br_taken = 1'b0; flush = 1'b1; flush_pc = 32'h1C00_9000;
        tick(); chk_fetch("pf1", 32'h1C00_9000);
        flush = 1'b0; stall = 6'd0;
        tick(); chk_fetch("pf2", 32'h1C00_9004);

        // A newer branch under stall replaces the older pending target.
        stall = 6'd1; br_taken = 1'b1; br_target = 32'h1C00_0500;
        tick(); chk_fetch("ow0", 32'h1C00_9004);
        br_target = 32'h1C00_0600;
        tick(); chk_fetch("ow1", 32'h1C00_9004);
        br_taken = 1'b0; stall = 6'd0;
        tick(); chk_fetch("ow2", 32'h1C00_0600);

        // Misaligned redirect target.
        flush = 1'b1; flush_pc = 32'h1C00_0002;
        tick(); chk_fetch("adef0", 32'h1C00_0002);
        flush = 1'b0;
        tick(); chk_fetch("adef1", 32'h1C00_0006);

        // PC wraps from the top of the address space.
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        tick(); chk_fetch("wrap0", 32'hFFFF_FFFC);
        flush = 1'b0;
        tick(); chk_fetch("wrap1", 32'h0000_0000);

        // Reset while a branch is pending restores everything.
        stall = 6'd1; br_taken = 1'b1; br_target = 32'h1C00_0700;
        tick(); chk_fetch("rp0", 32'h0000_0000);
        br_taken = 1'b0; reset = 1'b1;
        tick(); chk_reset("rp_rst");
        reset = 1'b0; stall = 6'd0;
        tick(); chk_fetch("rp1", 32'h1C00_0000);
        tick(); chk_fetch("rp2", 32'h1C00_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
